// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg_if
//  Purpose  : Receive-word handshake between uart_rx_cfg and the CPU-side
//             peripheral bus (word, per-word error flags, valid/ready).
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] m_data;
   logic                 m_frame_err;
   logic                 m_parity_err;
   logic                 m_valid;
   logic                 m_ready;

   // Receiver side: produces the word and its flags
   modport master (
      output m_data, m_frame_err, m_parity_err, m_valid,
      input  m_ready
   );

   // Consumer side: takes the word when valid && ready
   modport slave (
      input  m_data, m_frame_err, m_parity_err, m_valid,
      output m_ready
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg
//  Purpose  : Configurable UART receiver (5..8 data bits, none/even/odd
//             parity, 1 or 2 stop bits) with built-in fractional 16x baud
//             generator, 3-sample majority voting, break and overrun flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_cfg #(
   parameter int ACC_W     = 16,
   parameter int BAUD_INC  = 4832,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  wire logic      mclk,
   input  wire logic      reset,
   input  wire logic      serial,
   uart_rx_cfg_if.master  m,
   output logic           break_det,
   output logic           overrun
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_DATA     = 3'd2,
      S_PARITY   = 3'd3,
      S_STOP     = 3'd4,
      S_BRK_WAIT = 3'd5
   } state_t;

   localparam logic [2:0] LAST_BIT_C = 3'(DATA_BITS - 1);
   localparam logic       ODD_C      = (PARITY == 2);
   localparam logic       HAS_PAR_C  = (PARITY != 0);
   localparam logic       ONE_STOP_C = (STOP_BITS == 1);

   // ---------------------------------------------------------------- sync
   logic sync1_q, rx_s_q;

   // Two-flop synchroniser for the asynchronous line; idles high
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= serial;
         rx_s_q  <= sync1_q;
      end
   end

   // ---------------------------------------------------------------- baud
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W:0]   acc_d;
   logic             tick_q;

   assign acc_d = {1'b0, acc_q} + (ACC_W+1)'(BAUD_INC);

   // Free-running phase accumulator; its carry is the 16x oversampling tick
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d[ACC_W-1:0];
         tick_q <= acc_d[ACC_W];
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t               state_q;
   logic [3:0]           scnt_q;
   logic [2:0]           bcnt_q;
   logic                 s7_q, s8_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 zero_q;     // every bit so far (data, parity) was 0
   logic                 frm_q;      // an earlier stop bit of this word was 0
   logic                 perr_q;
   logic                 stop2_q;    // currently in the second stop bit
   logic                 brk_q;

   logic maj_d, at_stop9, last_stop, brk_hit, complete, ferr_d;

   // Third sample is the live rx_s at scnt 9
   assign maj_d     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
   assign at_stop9  = tick_q && (state_q == S_STOP) && (scnt_q == 4'd9);
   assign last_stop = ONE_STOP_C || stop2_q;
   assign brk_hit   = at_stop9 && !stop2_q && !maj_d && zero_q;
   assign complete  = at_stop9 && last_stop && !brk_hit;
   assign ferr_d    = frm_q | ~maj_d;

   // Frame sequencer: advances only on the oversampling tick
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         scnt_q  <= 4'd0;
         bcnt_q  <= 3'd0;
         s7_q    <= 1'b0;
         s8_q    <= 1'b0;
         shift_q <= '0;
         zero_q  <= 1'b0;
         frm_q   <= 1'b0;
         perr_q  <= 1'b0;
         stop2_q <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         brk_q <= 1'b0;
         if (tick_q) begin
            case (state_q)
               S_IDLE: begin
                  if (!rx_s_q) begin
                     state_q <= S_START;
                     scnt_q  <= 4'd0;
                     bcnt_q  <= 3'd0;
                     zero_q  <= 1'b1;
                     frm_q   <= 1'b0;
                     perr_q  <= 1'b0;
                     stop2_q <= 1'b0;
                  end
               end
               S_BRK_WAIT: begin
                  if (rx_s_q) state_q <= S_IDLE;
               end
               default: begin
                  scnt_q <= scnt_q + 4'd1;
                  if (scnt_q == 4'd7) s7_q <= rx_s_q;
                  if (scnt_q == 4'd8) s8_q <= rx_s_q;
                  if (scnt_q == 4'd9) begin
                     case (state_q)
                        S_START: if (maj_d) state_q <= S_IDLE;
                        S_DATA: begin
                           shift_q <= {maj_d, shift_q[DATA_BITS-1:1]};
                           if (maj_d) zero_q <= 1'b0;
                        end
                        S_PARITY: begin
                           perr_q <= (((^shift_q) ^ maj_d) != ODD_C);
                           if (maj_d) zero_q <= 1'b0;
                        end
                        S_STOP: begin
                           if (brk_hit) begin
                              brk_q   <= 1'b1;
                              state_q <= S_BRK_WAIT;
                           end else begin
                              frm_q <= ferr_d;
                              // Finish mid-bit to tolerate fast transmitters
                              if (last_stop) state_q <= S_IDLE;
                           end
                        end
                        default: ;
                     endcase
                  end
                  if (scnt_q == 4'd15) begin
                     case (state_q)
                        S_START: state_q <= S_DATA;
                        S_DATA: begin
                           if (bcnt_q == LAST_BIT_C) begin
                              bcnt_q  <= 3'd0;
                              state_q <= HAS_PAR_C ? S_PARITY : S_STOP;
                           end else begin
                              bcnt_q <= bcnt_q + 3'd1;
                           end
                        end
                        S_PARITY: state_q <= S_STOP;
                        S_STOP:   stop2_q <= 1'b1;
                        default: ;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- hold
   logic [DATA_BITS-1:0] data_q;
   logic                 hferr_q, hperr_q, valid_q, ovr_q;

   // Holding register: load on completion if free (or freed now), else drop
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         hferr_q <= 1'b0;
         hperr_q <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (complete) begin
            if (!valid_q || m.m_ready) begin
               data_q  <= shift_q;
               hferr_q <= ferr_d;
               hperr_q <= perr_q;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && m.m_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign m.m_data       = data_q;
   assign m.m_frame_err  = hferr_q;
   assign m.m_parity_err = hperr_q;
   assign m.m_valid      = valid_q;
   assign break_det      = brk_q;
   assign overrun        = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_cfg
//  Purpose  : Self-checking bench for uart_rx_cfg: three receivers
//             (8-N-1, 7-E-1, 8-N-2) on a 32-mclk bit time, scoreboarded.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;
   localparam int BIT_CLKS = 32;

   logic mclk  = 1'b0;
   logic reset = 1'b1;
   logic ser0  = 1'b1;
   logic ser1  = 1'b1;
   logic ser2  = 1'b1;
   logic bd0, bd1, bd2, ov0, ov1, ov2;

   int vectors     = 0;
   int miscompares = 0;
   int brk_cnt     = 0;
   int ovr_cnt     = 0;

   // Scoreboard entries: {frame_err, parity_err, data[7:0]}
   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic [9:0] q2[$];

   always #5 mclk = ~mclk;

   uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
   uart_rx_cfg_if #(.DATA_BITS(7)) if1 ();
   uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();

   uart_rx_cfg #(.ACC_W(8), .BAUD_INC(128), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .mclk(mclk), .reset(reset), .serial(ser0), .m(if0), .break_det(bd0), .overrun(ov0));
   uart_rx_cfg #(.ACC_W(8), .BAUD_INC(128), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
      .mclk(mclk), .reset(reset), .serial(ser1), .m(if1), .break_det(bd1), .overrun(ov1));
   uart_rx_cfg #(.ACC_W(8), .BAUD_INC(128), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
      .mclk(mclk), .reset(reset), .serial(ser2), .m(if2), .break_det(bd2), .overrun(ov2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input int depth, input logic [9:0] e,
                           input logic [7:0] d, input logic fe, input logic pe);
      check({tag, " word_expected"}, 32'(depth != 0), 32'd1);
      if (depth != 0) begin
         check({tag, " data"},       32'(d),  32'(e[7:0]));
         check({tag, " frame_err"},  32'(fe), 32'(e[9]));
         check({tag, " parity_err"}, 32'(pe), 32'(e[8]));
      end
   endtask

   task automatic set_line(input int idx, input logic v);
      case (idx)
         0:       ser0 = v;
         1:       ser1 = v;
         default: ser2 = v;
      endcase
   endtask

   task automatic bit_wait(input int n);
      repeat (n * BIT_CLKS) @(negedge mclk);
   endtask

   // pbit < 0 means no parity bit
   task automatic send(input int idx, input logic [7:0] d, input int nbits, input int pbit,
                       input logic s1, input logic s2, input int nstop);
      set_line(idx, 1'b0);
      bit_wait(1);
      for (int i = 0; i < nbits; i++) begin
         set_line(idx, d[i]);
         bit_wait(1);
      end
      if (pbit >= 0) begin
         set_line(idx, pbit[0]);
         bit_wait(1);
      end
      set_line(idx, s1);
      bit_wait(1);
      if (nstop == 2) begin
         set_line(idx, s2);
         bit_wait(1);
      end
      set_line(idx, 1'b1);
   endtask

   // Output monitor: samples just after the falling edge, i.e. the values
   // the next rising edge will act on
   int         n0, n1, n2;
   logic [9:0] e0, e1, e2;
   always begin
      @(negedge mclk);
      #2;
      if (bd0 || bd1 || bd2) brk_cnt++;
      if (ov0 || ov1 || ov2) ovr_cnt++;
      if (if0.m_valid && if0.m_ready) begin
         n0 = q0.size();
         e0 = '0;
         if (n0 != 0) e0 = q0.pop_front();
         sb_check("u0", n0, e0, if0.m_data, if0.m_frame_err, if0.m_parity_err);
      end
      if (if1.m_valid && if1.m_ready) begin
         n1 = q1.size();
         e1 = '0;
         if (n1 != 0) e1 = q1.pop_front();
         sb_check("u1", n1, e1, 8'(if1.m_data), if1.m_frame_err, if1.m_parity_err);
      end
      if (if2.m_valid && if2.m_ready) begin
         n2 = q2.size();
         e2 = '0;
         if (n2 != 0) e2 = q2.pop_front();
         sb_check("u2", n2, e2, if2.m_data, if2.m_frame_err, if2.m_parity_err);
      end
   end

   initial begin
      if0.m_ready = 1'b1;
      if1.m_ready = 1'b1;
      if2.m_ready = 1'b1;

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      check("rst m_valid",    32'(if0.m_valid),      32'd0);
      check("rst m_data",     32'(if0.m_data),       32'd0);
      check("rst frame_err",  32'(if0.m_frame_err),  32'd0);
      check("rst parity_err", 32'(if1.m_parity_err), 32'd0);
      check("rst break_det",  32'(bd0),              32'd0);
      check("rst overrun",    32'(ov0),              32'd0);
      reset = 1'b0;
      bit_wait(2);

      // 8-N-1 basic word
      q0.push_back({2'b00, 8'hA5});
      send(0, 8'hA5, 8, -1, 1'b1, 1'b1, 1);
      bit_wait(2);

      // 7-E-1: correct parity, then wrong parity
      q1.push_back({2'b00, 8'h41});
      send(1, 8'h41, 7, 0, 1'b1, 1'b1, 1);
      bit_wait(2);
      q1.push_back({2'b01, 8'h41});
      send(1, 8'h41, 7, 1, 1'b1, 1'b1, 1);
      bit_wait(2);

      // 8-N-2 with a low second stop bit
      q2.push_back({2'b10, 8'h3C});
      send(2, 8'h3C, 8, -1, 1'b1, 1'b0, 2);
      bit_wait(2);

      // Glitch (false start), break, then a normal byte
      ser0 = 1'b0;
      repeat (10) @(negedge mclk);
      ser0 = 1'b1;
      bit_wait(2);
      ser0 = 1'b0;
      bit_wait(12);
      ser0 = 1'b1;
      bit_wait(2);
      check("t4 break count", 32'(brk_cnt), 32'd1);
      q0.push_back({2'b00, 8'h55});
      send(0, 8'h55, 8, -1, 1'b1, 1'b1, 1);
      bit_wait(2);

      // Overrun, then refill in the same cycle the consumer frees the register
      if0.m_ready = 1'b0;
      q0.push_back({2'b00, 8'h11});
      send(0, 8'h11, 8, -1, 1'b1, 1'b1, 1);
      bit_wait(2);
      check("t5 held valid", 32'(if0.m_valid), 32'd1);
      check("t5 held data",  32'(if0.m_data),  32'h11);
      send(0, 8'h22, 8, -1, 1'b1, 1'b1, 1);
      bit_wait(2);
      check("t5 still 0x11", 32'(if0.m_data), 32'h11);
      check("t5 overrun",    32'(ovr_cnt),    32'd1);
      q0.push_back({2'b00, 8'h33});
      fork
         send(0, 8'h33, 8, -1, 1'b1, 1'b1, 1);
         begin
            int k;
            k = 0;
            // Receiver's completion strobe used only to time the ready pulse
            while (!u0.complete && k < 2000) begin
               @(negedge mclk);
               k++;
            end
            check("t5 completion seen", 32'(k < 2000), 32'd1);
            if0.m_ready = 1'b1;
            @(negedge mclk);
            if0.m_ready = 1'b0;
         end
      join
      bit_wait(1);
      check("t5 loaded 0x33", 32'(if0.m_data), 32'h33);
      check("t5 no new ovr",  32'(ovr_cnt),    32'd1);
      if0.m_ready = 1'b1;
      bit_wait(1);

      // Reset in the middle of data bit 4
      ser0 = 1'b0;
      bit_wait(1);
      for (int i = 0; i < 4; i++) begin
         ser0 = 1'b1;
         bit_wait(1);
      end
      repeat (BIT_CLKS / 2) @(negedge mclk);
      reset = 1'b1;
      #1;
      check("t6 rst m_data",  32'(if0.m_data),  32'd0);
      check("t6 rst m_valid", 32'(if0.m_valid), 32'd0);
      ser0 = 1'b1;
      repeat (3) @(negedge mclk);
      reset = 1'b0;
      bit_wait(2);
      q0.push_back({2'b00, 8'h7E});
      send(0, 8'h7E, 8, -1, 1'b1, 1'b1, 1);
      bit_wait(3);

      // Everything expected was delivered
      check("end q0 empty",  32'(q0.size()), 32'd0);
      check("end q1 empty",  32'(q1.size()), 32'd0);
      check("end q2 empty",  32'(q2.size()), 32'd0);
      check("end breaks",    32'(brk_cnt),   32'd1);
      check("end overruns",  32'(ovr_cnt),   32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised successor to the fixed 8-N-1 receiver.
- Integrates its own fractional baud generator at 16x oversampling, so no external baud_x4 strobe is needed.
- Supports 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits, with 3-sample majority voting.
- Reports per-word frame and parity errors, flags line breaks and overruns, and delivers words through a valid/ready handshake to the CPU-side peripheral bus.

Parameters:
ACC_W, 16, baud phase-accumulator width in bits
BAUD_INC, 4832, accumulator increment per mclk; 16x tick rate = mclk*BAUD_INC/2^ACC_W (4832 gives 16*115200 at 25 MHz); must satisfy 1 <= BAUD_INC < 2^ACC_W
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0=none, 1=even, 2=odd
STOP_BITS, 1, 1 or 2

Ports:
mclk  in  1  clock
reset  in  1  asynchronous active-high reset
serial  in  1  asynchronous RX line, idle high
m_data  out  DATA_BITS  received word, LSB = first bit received
m_frame_err  out  1  a stop bit of the held word sampled 0
m_parity_err  out  1  parity mismatch on the held word (always 0 when PARITY=0)
m_valid  out  1  holding register full
m_ready  in  1  consumer accepts the word when m_valid && m_ready
break_det  out  1  one-cycle pulse on break detection
overrun  out  1  one-cycle pulse when a completed word is dropped

Behaviour:
Reset:
- Asynchronous, active-high. Clears the accumulator, all counters, state = IDLE, m_valid, both error flags, break_det, overrun, and m_data.
- Both synchroniser flops reset to 1 (line idle).
- Reset mid-frame aborts the frame silently.

Input path:
- serial passes through two flops to give rx_s; latency 2 mclk.

Baud generator:
- acc <= acc + BAUD_INC, free-running, never resynchronised.
- tick = carry out of the ACC_W-bit add, registered: one-cycle pulse.

FSM (all advances happen only on tick):
- IDLE: when rx_s == 0, go to START with scnt = 0.
- Sample handling in every non-IDLE state:
  - scnt increments mod 16.
  - rx_s is captured at scnt = 7, 8 and 9.
  - At scnt = 9, bit = majority of the three samples.
  - At scnt = 15, advance to the next bit.
- START: majority 1 at scnt 9 is a false start; return to IDLE with no outputs.
- DATA: shift majority bits in LSB-first; after DATA_BITS bits go to PARITY, or to STOP if PARITY = 0.
- PARITY: compute error = (XOR of data bits ^ received bit) != (PARITY == 2).
  - Even parity: total count of ones including the parity bit is even.
- STOP (first and, if STOP_BITS = 2, second stop bit):
  - Any stop bit with majority 0 sets the frame error for the word.
  - Completion happens at scnt 9 of the last stop bit; the FSM returns to IDLE at that same tick (half-bit early, tolerating fast transmitters).
- BRK_WAIT: stay until a tick samples rx_s == 1, then go to IDLE.

Break:
- Condition: all data bits 0, parity bit (if present) 0, and first stop bit 0.
- Response:
  - break_det pulses one cycle.
  - No word is delivered.
  - A second stop bit is not sampled.
  - FSM enters BRK_WAIT.

Completion and handshake:
- Completion with the holding register free, or freed in the same cycle (m_valid && m_ready):
  - The next mclk loads m_data and both error flags, and asserts m_valid.
- Completion with m_valid = 1 and m_ready = 0:
  - The word is dropped and overrun pulses one cycle.
  - The held word and its flags are unchanged.
- m_valid clears the cycle after m_valid && m_ready when there is no simultaneous completion.
- m_data and the flags are stable while m_valid = 1 and are not consumed.

Width rules:
- Unused data bits do not exist (m_data is exactly DATA_BITS wide).
- scnt is 4 bits.
- The bit counter is 3 bits and wraps only under FSM control.

Test Plan:
1. Setup: ACC_W=8, BAUD_INC=128 (tick every 2 mclk, bit = 32 mclk), 8-N-1, m_ready=1. Send 0xA5. Required: m_valid one cycle with m_data=0xA5 and no errors.
2. Setup: PARITY=1, DATA_BITS=7. Send 0x41 with parity 0, then 0x41 with parity 1. Required: m_parity_err=0, then m_parity_err=1; m_data=0x41 both times.
3. Setup: STOP_BITS=2. Send 0x3C with second stop bit 0. Required: m_data=0x3C, m_frame_err=1.
4. Stimulus: a 10-mclk low glitch, then a 12-bit-time low followed by a return high. Required: no word for the glitch (false start); one break_det pulse; no m_valid; the next byte 0x55 is received correctly.
5. Stimulus: m_ready=0, send 0x11 then 0x22. Required: m_data holds 0x11 and overrun pulses once. Then raise m_ready in the same cycle as 0x33 completes. Required: 0x33 is loaded, no overrun.
6. Stimulus: assert reset at mid-data bit 4 of a frame, release, send 0x7E. Required: outputs cleared immediately; only 0x7E is delivered.
